// File: rtl/master_cmd_queue.sv
// master_cmd_queue: command FIFO in front of master_module.
// Buffers host bus commands, issues them one at a time to the master over a
// valid/ready channel, waits for completion (or timeout), and returns one
// response pulse per command in command order.
//
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : host command handshake, with cmd_addr/cmd_write/cmd_wdata
//   mst_req_valid/ready : request to master, with mst_addr/mst_write/mst_wdata
//   mst_rsp_valid       : master completion strobe, with mst_rsp_rdata
//   rsp_valid           : one-cycle response pulse, with rsp_addr/rsp_rdata/rsp_error
//   busy                : queue non-empty or a command is in flight
module master_cmd_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  mst_req_valid,
  input  logic                  mst_req_ready,
  output logic [ADDR_WIDTH-1:0] mst_addr,
  output logic                  mst_write,
  output logic [DATA_WIDTH-1:0] mst_wdata,
  input  logic                  mst_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mst_rsp_rdata,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    REPORT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  cmd_t             fifo_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Command currently owned by the FSM; drives the master request fields.
  cmd_t req_q, req_d;

  // Result captured at completion, presented to the host in REPORT.
  logic [DATA_WIDTH-1:0] res_rdata_q, res_rdata_d;
  logic                  res_err_q, res_err_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  req_valid_q, req_valid_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  busy_q, busy_d;

  logic push;
  logic pop;
  cmd_t cmd_in;

  assign cmd_in = '{addr: cmd_addr, write: cmd_write, wdata: cmd_wdata};

  // FIFO storage; contents need no reset, validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= cmd_in;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      req_q       <= '0;
      res_rdata_q <= '0;
      res_err_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      req_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      req_q       <= req_d;
      res_rdata_q <= res_rdata_d;
      res_err_q   <= res_err_d;
      cmd_ready_q <= cmd_ready_d;
      req_valid_q <= req_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, FIFO bookkeeping and registered-output computation.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    tmo_d       = tmo_q;
    req_d       = req_q;
    res_rdata_d = res_rdata_q;
    res_err_d   = res_err_q;
    rsp_valid_d = 1'b0;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    pop         = 1'b0;

    // cmd_ready_q reflects the registered count only.
    push = cmd_valid && cmd_ready_q;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          req_d   = fifo_q[rd_ptr_q];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mst_req_ready) begin
          tmo_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        tmo_d = tmo_q + TMO_W'(1);
        // A response on the final cycle still counts as success.
        if (mst_rsp_valid) begin
          res_rdata_d = req_q.write ? '0 : mst_rsp_rdata;
          res_err_d   = 1'b0;
          state_d     = REPORT;
        end else if (tmo_d == TMO_W'(TIMEOUT)) begin
          res_rdata_d = '0;
          res_err_d   = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        rsp_valid_d = 1'b1;
        rsp_addr_d  = req_q.addr;
        rsp_rdata_d = res_rdata_q;
        rsp_error_d = res_err_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    cmd_ready_d = (count_d != CNT_W'(DEPTH));
    req_valid_d = (state_d == ISSUE);
    busy_d      = (count_d != '0) || (state_d != IDLE);
  end

  assign cmd_ready     = cmd_ready_q;
  assign mst_req_valid = req_valid_q;
  assign mst_addr      = req_q.addr;
  assign mst_write     = req_q.write;
  assign mst_wdata     = req_q.wdata;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_addr      = rsp_addr_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_error     = rsp_error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_master_cmd_queue.sv
// Bench for master_cmd_queue: transaction-level reference model compared to
// the DUT on every falling edge, plus directed scenarios with literal checks.
module tb_master_cmd_queue;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_write = 1'b0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          mst_req_valid;
  logic          mst_req_ready = 1'b0;
  logic [AW-1:0] mst_addr;
  logic          mst_write;
  logic [DW-1:0] mst_wdata;
  logic          mst_rsp_valid;
  logic [DW-1:0] mst_rsp_rdata;
  logic          rsp_valid;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          busy;

  always #5 clk = ~clk;

  master_cmd_queue #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .mst_req_valid(mst_req_valid), .mst_req_ready(mst_req_ready),
    .mst_addr(mst_addr), .mst_write(mst_write), .mst_wdata(mst_wdata),
    .mst_rsp_valid(mst_rsp_valid), .mst_rsp_rdata(mst_rsp_rdata),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
  } cmd_s;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } rsp_s;

  cmd_s mq[$];          // accepted, not yet taken by the engine
  cmd_s cur;            // command owned by the engine
  int   phase = 0;      // 0 free, 1 offering to master, 2 awaiting master, 3 answering
  int   waited = 0;
  logic [DW-1:0] res_data = '0;
  logic          res_err = 1'b0;
  logic          m_push;
  logic          e_rsp_valid = 1'b0;
  logic [AW-1:0] e_rsp_addr = '0;
  logic [DW-1:0] e_rsp_rdata = '0;
  logic          e_rsp_error = 1'b0;
  logic [AW-1:0] e_maddr = '0;
  logic          e_mwr = 1'b0;
  logic [DW-1:0] e_mwdata = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      phase = 0; waited = 0; res_data = '0; res_err = 1'b0;
      e_rsp_valid = 1'b0; e_rsp_addr = '0; e_rsp_rdata = '0; e_rsp_error = 1'b0;
      e_maddr = '0; e_mwr = 1'b0; e_mwdata = '0;
    end else begin
      m_push = cmd_valid && (mq.size() < DEPTH);
      e_rsp_valid = 1'b0;
      case (phase)
        0: if (mq.size() > 0) begin
             cur = mq.pop_front();
             e_maddr = cur.addr; e_mwr = cur.wr; e_mwdata = cur.wdata;
             phase = 1;
           end
        1: if (mst_req_ready) begin waited = 0; phase = 2; end
        2: begin
             waited++;
             if (mst_rsp_valid) begin
               res_data = cur.wr ? '0 : mst_rsp_rdata; res_err = 1'b0; phase = 3;
             end else if (waited == TMO) begin
               res_data = '0; res_err = 1'b1; phase = 3;
             end
           end
        default: begin
             e_rsp_valid = 1'b1; e_rsp_addr = cur.addr;
             e_rsp_rdata = res_data; e_rsp_error = res_err;
             phase = 0;
           end
      endcase
      if (m_push) mq.push_back('{cmd_addr, cmd_write, cmd_wdata});
    end
  end

  // ---------------- per-cycle compare ----------------
  rsp_s rlog[$];

  always @(negedge clk) begin
    chk("cmd_ready", 64'(cmd_ready), 64'(mq.size() < DEPTH));
    chk("busy", 64'(busy), 64'((mq.size() != 0) || (phase != 0)));
    chk("mst_req_valid", 64'(mst_req_valid), 64'(phase == 1));
    chk("mst_addr", 64'(mst_addr), 64'(e_maddr));
    chk("mst_write", 64'(mst_write), 64'(e_mwr));
    chk("mst_wdata", 64'(mst_wdata), 64'(e_mwdata));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
    chk("rsp_addr", 64'(rsp_addr), 64'(e_rsp_addr));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rsp_rdata));
    chk("rsp_error", 64'(rsp_error), 64'(e_rsp_error));
    if (rsp_valid) rlog.push_back('{rsp_addr, rsp_rdata, rsp_error, cyc});
  end

  // ---------------- master responder ----------------
  int            rsp_lat = 0;     // 0 = never answer
  logic [DW-1:0] rsp_data = '0;
  logic          rsp_fire = 1'b0;
  logic          stray = 1'b0;
  int            pend = 0;
  int            hs_cyc = 0;

  assign mst_rsp_valid = rsp_fire | stray;
  assign mst_rsp_rdata = rsp_data;

  always begin
    @(posedge clk);
    if (reset && mst_req_valid && mst_req_ready) begin
      hs_cyc = cyc + 1;
      pend = rsp_lat;
    end
    @(negedge clk);
    rsp_fire = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) rsp_fire = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    int n;
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rlog.size() < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_count", 64'(rlog.size()), 64'(target));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_req_valid", 64'(mst_req_valid), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // Single read.
    mst_req_ready = 1'b1; rsp_lat = 3; rsp_data = 32'hDEAD_BEEF;
    push(8'hA5, 1'b0, '0);
    wait_rsp(1);
    if (rlog.size() >= 1) begin
      chk("read_addr", 64'(rlog[0].addr), 64'h A5);
      chk("read_rdata", 64'(rlog[0].rdata), 64'hDEAD_BEEF);
      chk("read_err", 64'(rlog[0].err), 64'(0));
      chk("read_latency", 64'(rlog[0].cyc - hs_cyc), 64'(4));
    end

    // Write ack; request appears one falling edge after the push completes.
    rsp_lat = 2; rsp_data = 32'hFFFF_0000;
    push(8'hB2, 1'b1, 32'h1234_5678);
    chk("wr_req_not_yet", 64'(mst_req_valid), 64'(0));
    @(negedge clk);
    chk("wr_req_valid", 64'(mst_req_valid), 64'(1));
    chk("wr_req_addr", 64'(mst_addr), 64'h B2);
    chk("wr_req_write", 64'(mst_write), 64'(1));
    chk("wr_req_wdata", 64'(mst_wdata), 64'h1234_5678);
    wait_rsp(2);
    if (rlog.size() >= 2) begin
      chk("wr_addr", 64'(rlog[1].addr), 64'h B2);
      chk("wr_rdata", 64'(rlog[1].rdata), 64'(0));
      chk("wr_err", 64'(rlog[1].err), 64'(0));
    end

    // Fill with the master stalled: one command in the request slot, four queued.
    mst_req_ready = 1'b0; rsp_lat = 1; rsp_data = 32'h55;
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b0, '0);
    chk("full_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("full_busy", 64'(busy), 64'(1));
    chk("full_req_addr", 64'(mst_addr), 64'(1));
    mst_req_ready = 1'b1;
    wait_rsp(7);
    for (int i = 0; i < 5; i++) begin
      if (rlog.size() > 2 + i) chk("order_addr", 64'(rlog[2+i].addr), 64'(i + 1));
    end

    // Timeout, then a normal command.
    rsp_lat = 0;
    push(8'hC0, 1'b0, '0);
    wait_rsp(8);
    if (rlog.size() >= 8) begin
      chk("tmo_addr", 64'(rlog[7].addr), 64'h C0);
      chk("tmo_err", 64'(rlog[7].err), 64'(1));
      chk("tmo_rdata", 64'(rlog[7].rdata), 64'(0));
      chk("tmo_latency", 64'(rlog[7].cyc - hs_cyc), 64'(TMO + 1));
    end
    rsp_lat = 2; rsp_data = 32'h77;
    push(8'hC1, 1'b0, '0);
    wait_rsp(9);
    if (rlog.size() >= 9) begin
      chk("after_tmo_err", 64'(rlog[8].err), 64'(0));
      chk("after_tmo_rdata", 64'(rlog[8].rdata), 64'h77);
    end

    // Stray completion while idle is ignored.
    repeat (2) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (5) @(negedge clk);
    chk("stray_no_rsp", 64'(rlog.size()), 64'(9));
    chk("stray_busy", 64'(busy), 64'(0));

    // Response on the last allowed cycle is a success.
    rsp_lat = TMO; rsp_data = 32'hA1B2_C3D4;
    push(8'hD0, 1'b0, '0);
    wait_rsp(10);
    if (rlog.size() >= 10) begin
      chk("edge_err", 64'(rlog[9].err), 64'(0));
      chk("edge_rdata", 64'(rlog[9].rdata), 64'hA1B2_C3D4);
      chk("edge_latency", 64'(rlog[9].cyc - hs_cyc), 64'(TMO + 1));
    end

    // Asynchronous reset while waiting with two commands queued.
    rsp_lat = 0;
    push(8'hE1, 1'b0, '0);
    push(8'hE2, 1'b0, '0);
    push(8'hE3, 1'b1, 32'hCAFE_F00D);
    repeat (2) @(posedge clk);
    chk("pre_reset_busy", 64'(busy), 64'(1));
    #2 reset = 1'b0;
    #1;
    chk("arst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_req_valid", 64'(mst_req_valid), 64'(0));
    chk("arst_mst_addr", 64'(mst_addr), 64'(0));
    chk("arst_mst_wdata", 64'(mst_wdata), 64'(0));
    chk("arst_rsp_addr", 64'(rsp_addr), 64'(0));
    chk("arst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_no_rsp", 64'(rlog.size()), 64'(10));
    chk("post_reset_busy", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/master_cmd_queue.md
Name: master_cmd_queue

Overview:
- Command-queue stage directly upstream of master_module.
- Buffers host bus transactions (8-bit slave address, write flag, 32-bit write data) in a FIFO.
- Issues them to the master one at a time over a valid/ready request channel, then waits for the master's completion.
- Returns one response per command, including a timeout error when no slave answers.

Parameters:
DATA_WIDTH, 32, width of write/read data; matches bus_if DATA_WIDTH
ADDR_WIDTH, 8, slave address width
DEPTH, 4, FIFO entries; power of two, >= 2
TIMEOUT, 16, max cycles waited for mst_rsp_valid after issue; >= 1

Ports:
clk  input  1  single clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  host command present
cmd_ready  output  1  queue can accept a command
cmd_addr  input  ADDR_WIDTH  target slave address
cmd_write  input  1  1 = write, 0 = read
cmd_wdata  input  DATA_WIDTH  write data (don't-care for reads)
mst_req_valid  output  1  request to master valid
mst_req_ready  input  1  master accepts request
mst_addr  output  ADDR_WIDTH  request address
mst_write  output  1  request direction
mst_wdata  output  DATA_WIDTH  request write data
mst_rsp_valid  input  1  master reports transaction complete
mst_rsp_rdata  input  DATA_WIDTH  read data from master
rsp_valid  output  1  one-cycle response pulse to host
rsp_addr  output  ADDR_WIDTH  address of completed command
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors
rsp_error  output  1  1 = timeout
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - FIFO empty, pointers and count 0, FSM IDLE, timeout counter 0.
  - cmd_ready=1; mst_req_valid=0; mst_addr/mst_write/mst_wdata=0; rsp_valid=0; rsp_addr/rsp_rdata/rsp_error=0; busy=0.
- FIFO:
  - Push when cmd_valid && cmd_ready; cmd_ready = !full, registered count only, no dependence on same-cycle pop.
  - Pop occurs when the FSM loads the head entry.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
  - count range 0..DEPTH; full when count==DEPTH.
- FSM states IDLE, ISSUE, WAIT_RSP, REPORT:
  - IDLE: if FIFO non-empty, pop head into request registers, go to ISSUE next cycle. Latency push-to-mst_req_valid = 2 cycles when idle and empty.
  - ISSUE: mst_req_valid=1, outputs held stable until mst_req_ready=1. On handshake: counter cleared, go to WAIT_RSP.
  - WAIT_RSP: mst_req_valid=0; counter increments each cycle.
    - mst_rsp_valid=1: capture mst_rsp_rdata (0 if write), rsp_error=0, go to REPORT.
    - Counter reaches TIMEOUT with no response: rsp_rdata=0, rsp_error=1, go to REPORT.
    - mst_rsp_valid in the same cycle the counter reaches TIMEOUT: treated as success.
  - REPORT: rsp_valid=1 for exactly one cycle with rsp_addr = issued address, then IDLE. No host backpressure.
- Response fields hold their last values between pulses.
- Only one outstanding transaction. mst_rsp_valid outside WAIT_RSP is ignored.
- Responses emitted in command order.
- Reset mid-operation: queued and in-flight commands are discarded, no response emitted, all outputs return to reset values immediately.

Test Plan:
- Single read: push addr 8'hA5 read; master ready immediately, rsp_valid with rdata 32'hDEAD_BEEF 3 cycles later -> one rsp_valid pulse, rsp_addr=8'hA5, rsp_rdata=32'hDEAD_BEEF, rsp_error=0.
- Write ack: push addr 8'hB2 write 32'h1234_5678 -> mst_wdata=32'h1234_5678 while mst_req_valid; on completion rsp_rdata=0, rsp_error=0.
- Fill/backpressure: mst_req_ready=0, push 5 commands with DEPTH=4 -> first command moves into the request registers, so 4 more are accepted and cmd_ready drops after them. Release ready -> 5 responses in push order (addresses 1..5).
- Timeout: push read to 8'hC0, never assert mst_rsp_valid -> rsp_valid exactly TIMEOUT+1 cycles after issue handshake, rsp_error=1, rsp_rdata=0. Next command then proceeds normally.
- Stray/edge responses: mst_rsp_valid pulsed while IDLE is ignored. Response on the exact TIMEOUT cycle yields rsp_error=0.
- Async reset mid-WAIT_RSP with 2 queued: assert reset between edges -> outputs zero immediately, cmd_ready=1, busy=0, no responses after release.
